// File: rtl/fir_tap_if.sv
// Streaming port bundle for the fir_tap moving-sum filter.
// The master drives the qualified sample stream. The slave returns the window sum.
interface fir_tap_if #(
    parameter int tapSize = 4,
    parameter int width   = 16
);
    localparam int out_w = $clog2(tapSize) + width;

    logic             in_valid;
    logic [width-1:0] in;
    logic             out_valid;
    logic [out_w-1:0] out;

    modport master (output in_valid, output in, input  out_valid, input  out);
    modport slave  (input  in_valid, input  in, output out_valid, output out);
endinterface

// File: rtl/fir_tap.sv
// Boxcar FIR: the sum of the last tapSize accepted samples, computed over a registered delay line.
// The adder tree is combinational. out_valid marks the point where the window has filled.
module fir_tap #(
    parameter int tapSize = 4,
    parameter int width   = 16
) (
    input  logic       clk,
    input  logic       reset,
    fir_tap_if.slave   bus
);
    localparam int out_w = $clog2(tapSize) + width;
    localparam int cnt_w = $clog2(tapSize + 1);
    localparam int lvls  = $clog2(tapSize);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(tapSize);

    logic [width-1:0] in_temp [tapSize];
    logic [cnt_w-1:0] fill_cnt;
    logic [out_w-1:0] tree [lvls+1][tapSize];

    // NOTE: the delay line is a real register array and not a RAM. Clearing it on reset is what makes out read 0 during reset.
    // NOTE: all state here uses <=, so every tap samples its neighbour's pre-edge value and the line shifts by exactly one place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < tapSize; k++) in_temp[k] <= '0;
            fill_cnt <= '0;
        end else if (bus.in_valid) begin
            in_temp[0] <= bus.in;
            for (int k = 1; k < tapSize; k++) in_temp[k] <= in_temp[k-1];
            if (fill_cnt != full_cnt) fill_cnt <= fill_cnt + cnt_w'(1);
        end
    end

    for (genvar i = 0; i < tapSize; i++) begin : g_leaf
        assign tree[0][i] = out_w'(in_temp[i]);
    end

    // Each level pairs up neighbouring operands. An odd operand at the end passes through unchanged. Unused slots are tied to 0.
    for (genvar l = 0; l < lvls; l++) begin : g_lvl
        localparam int n_cur = (tapSize + (1 << l) - 1) >> l;
        for (genvar i = 0; i < tapSize; i++) begin : g_node
            if (2*i + 1 < n_cur) begin : g_add
                assign tree[l+1][i] = tree[l][2*i] + tree[l][2*i+1];
            end else if (2*i < n_cur) begin : g_pass
                assign tree[l+1][i] = tree[l][2*i];
            end else begin : g_zero
                assign tree[l+1][i] = '0;
            end
        end
    end

    assign bus.out       = tree[lvls][0];
    assign bus.out_valid = (fill_cnt == full_cnt);
endmodule

// File: tb/tb_fir_tap.sv
// Self-checking bench for fir_tap. It runs table vectors and randomised streams against a queue-based window model.
// It also covers the in_valid gap, an asynchronous mid-stream reset and a tapSize=3/width=8 instance.
module tb_fir_tap;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int OW = 18;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fir_tap_if #(.tapSize(N), .width(W)) bus_a ();
    fir_tap_if #(.tapSize(3), .width(8)) bus_b ();

    fir_tap #(.tapSize(N), .width(W)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    fir_tap #(.tapSize(3), .width(8)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the accepted samples that are still inside the window.
    logic [W-1:0] hist [$];

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic [OW-1:0] exp_out;
        logic          exp_valid;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [63:0] model_sum();
        logic [63:0] s = 0;
        foreach (hist[i]) s += 64'(hist[i]);
        return s;
    endfunction

    task automatic drive_a(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        bus_a.in_valid = v;
        bus_a.in       = d;
        @(posedge clk);
        #1;
        if (v) begin
            hist.push_back(d);
            if (hist.size() > N) void'(hist.pop_front());
        end
    endtask

    task automatic check_model(input string name);
        check({name, "_out"},   64'(bus_a.out),       model_sum());
        check({name, "_valid"}, 64'(bus_a.out_valid), 64'(hist.size() == N));
    endtask

    initial begin
        bus_a.in_valid = 1'b0;
        bus_a.in       = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in       = '0;

        vecs[0] = '{1'b1, 16'd1,      18'd1,      1'b0};
        vecs[1] = '{1'b1, 16'd2,      18'd3,      1'b0};
        vecs[2] = '{1'b1, 16'd3,      18'd6,      1'b0};
        vecs[3] = '{1'b1, 16'd4,      18'd10,     1'b1};
        vecs[4] = '{1'b1, 16'd5,      18'd14,     1'b1};
        vecs[5] = '{1'b1, 16'd6,      18'd18,     1'b1};
        vecs[6] = '{1'b1, 16'hFFFF,   18'd65550,  1'b1};
        vecs[7] = '{1'b1, 16'hFFFF,   18'd131081, 1'b1};
        vecs[8] = '{1'b1, 16'hFFFF,   18'd196611, 1'b1};
        vecs[9] = '{1'b1, 16'hFFFF,   18'h3FFFC,  1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_a",   64'(bus_a.out),       64'd0);
        check("reset_valid_a", 64'(bus_a.out_valid), 64'd0);
        check("reset_out_b",   64'(bus_b.out),       64'd0);
        check("reset_valid_b", 64'(bus_b.out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill, slide and max-value table
        for (int i = 0; i < 10; i++) begin
            drive_a(vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d_out", i),   64'(bus_a.out),       64'(vecs[i].exp_out));
            check($sformatf("vec%0d_valid", i), 64'(bus_a.out_valid), 64'(vecs[i].exp_valid));
        end

        // Random stream with occasional in_valid gaps
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                drive_a(1'b0, W'($urandom));
                check_model($sformatf("rnd_gap%0d", i));
            end
            drive_a(1'b1, W'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        // Hold for three idle cycles while in keeps changing
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, W'($urandom));
            check_model($sformatf("hold%0d", i));
        end
        @(negedge clk);
        bus_a.in = ~bus_a.in;
        #2;
        check("between_edges_out", 64'(bus_a.out), model_sum());

        // Asynchronous reset asserted between clock edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        hist.delete();
        check("midreset_out",   64'(bus_a.out),       64'd0);
        check("midreset_valid", 64'(bus_a.out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Refill needs tapSize new samples
        drive_a(1'b1, 16'd7);  check_model("refill1");
        drive_a(1'b1, 16'd8);  check_model("refill2");
        drive_a(1'b1, 16'd9);  check_model("refill3");
        drive_a(1'b1, 16'd10);
        check("refill4_out",   64'(bus_a.out),       64'd34);
        check("refill4_valid", 64'(bus_a.out_valid), 64'd1);

        // tapSize=3, width=8 instance driven with all-ones samples
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus_b.in_valid = 1'b1;
            bus_b.in       = 8'hFF;
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d_out", k),   64'(bus_b.out),       64'((k >= 2) ? 765 : (k + 1) * 255));
            check($sformatf("sweep%0d_valid", k), 64'(bus_b.out_valid), 64'(k >= 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
